regfile_wb_sched: RTL and testbench
===================================

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 31, meaning MSB index of the write data (data width DATA_WIDTH+1).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports alu_valid input 1, alu_reg input 4, alu_data input DATA_WIDTH+1, alu_ready output 1: ALU writeback request.
REQ-005 SHALL have ports mem_valid input 1, mem_reg input 4, mem_data input DATA_WIDTH+1, mem_ready output 1: load writeback request.
REQ-006 SHALL have ports rsv_valid input 1, rsv_reg input 4, rsv_ready output 1: issue-stage reservation of a destination register.
REQ-007 SHALL have ports rd_a input 4, rd_b input 4, hazard output 1: source registers of the instruction in issue, and a stall indication.
REQ-008 SHALL have ports rf_enable output 1, rf_InReg output 4, rf_In output DATA_WIDTH+1: register-file write port drive.
REQ-009 SHALL have ports fwd_a_hit, fwd_b_hit output 1 and fwd_a_data, fwd_b_data output DATA_WIDTH+1 (active only under REQ-025).

Function
REQ-010 SHALL transfer a request only in a cycle where valid and ready are both 1; a requester holds valid, reg and data stable until ready.
REQ-011 SHALL grant at most one requester per cycle; ready is combinational from valid and the priority pointer, and is 0 for the loser.
REQ-012 SHALL keep a 1-bit round-robin pointer: on contention the pointed-to requester wins; after any grant the pointer moves to the other requester; with no grant it holds.
REQ-013 SHALL register the granted write: rf_enable=1 with rf_InReg/rf_In for exactly the cycle after the handshake (latency 1); rf_enable=0 otherwise.
REQ-014 SHALL keep a 16-bit busy scoreboard; rsv handshake (rsv_valid & rsv_ready) sets busy[rsv_reg] on the next edge.
REQ-015 SHALL clear busy[rf_InReg] on the edge ending a cycle with rf_enable=1.
REQ-016 SHALL drive rsv_ready=0 while busy[rsv_reg]=1 (WAW stall), except when that reg is being cleared in the same cycle, where rsv_ready=1 and set wins.
REQ-017 SHALL accept writes to non-busy registers without changing the scoreboard.
REQ-018 SHALL drive hazard = busy[rd_a] | busy[rd_b], combinationally, modified only per REQ-025.
REQ-019 SHALL treat all 16 registers (0-15) identically; none is hardwired.
REQ-020 SHALL with only one valid requester grant it regardless of pointer, in the same cycle.

Reset
REQ-021 SHALL on rst=1 at a rising edge clear busy to 0, set pointer to ALU, and drive rf_enable=0, rf_InReg=0, rf_In=0.
REQ-022 SHALL hold alu_ready, mem_ready, rsv_ready at 0 while rst=1; a write registered before reset is dropped and never reaches rf_enable.
REQ-023 SHALL drive hazard=0 and fwd_*_hit=0, fwd_*_data=0 while rst=1.

Configuration
REQ-024 SHALL compile forwarding only when macro REGFILE_WB_BYPASS_EN is defined.
REQ-025 SHALL with REGFILE_WB_BYPASS_EN: fwd_a_hit=rf_enable&(rf_InReg==rd_a), fwd_a_data=rf_In (same for b), and a register covered by a hit does not contribute to hazard.
REQ-026 SHALL without REGFILE_WB_BYPASS_EN tie fwd_*_hit and fwd_*_data to 0 and use REQ-018 unmodified.

Verification
REQ-027 SHALL cover: reset, then alu_valid=1 reg=5 data=0x1234 -> alu_ready=1, next cycle rf_enable=1 rf_InReg=5 rf_In=0x1234, then rf_enable=0.
REQ-028 SHALL cover: alu and mem valid for 4 cycles (regs 1 and 2) -> grants ALU,MEM,ALU,MEM; four single-cycle writes in that order.
REQ-029 SHALL cover: rsv reg=7, then rd_a=7 -> hazard=1; mem write reg 7 -> hazard=0 the cycle after rf_enable (bypass build: hazard=0, fwd_a_hit=1 during rf_enable).
REQ-030 SHALL cover: busy[3]=1, rsv reg=3 -> rsv_ready=0; in the rf_enable cycle for reg 3 -> rsv_ready=1, busy[3] stays 1 afterwards.
REQ-031 SHALL cover: handshake on reg 9 then rst=1 next cycle -> rf_enable stays 0, busy=0, pointer=ALU.

Source files
------------

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin ALU/MEM arbitration, busy scoreboard, optional bypass.
// Ports: clk, rst; alu_*/mem_* writeback requests; rsv_* reservation; rd_a/rd_b, hazard; rf_* write port; fwd_* bypass.
// Optional feature: define REGFILE_WB_BYPASS_EN to compile writeback forwarding.
module regfile_wb_sched #(
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [3:0]            alu_reg,
  input  logic [DATA_WIDTH:0]   alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [3:0]            mem_reg,
  input  logic [DATA_WIDTH:0]   mem_data,
  output logic                  mem_ready,
  input  logic                  rsv_valid,
  input  logic [3:0]            rsv_reg,
  output logic                  rsv_ready,
  input  logic [3:0]            rd_a,
  input  logic [3:0]            rd_b,
  output logic                  hazard,
  output logic                  rf_enable,
  output logic [3:0]            rf_InReg,
  output logic [DATA_WIDTH:0]   rf_In,
  output logic                  fwd_a_hit,
  output logic                  fwd_b_hit,
  output logic [DATA_WIDTH:0]   fwd_a_data,
  output logic [DATA_WIDTH:0]   fwd_b_data
);

  // ptr: 0 = ALU has priority, 1 = MEM has priority
  logic                ptr;
  logic [15:0]         busy;
  logic [15:0]         busy_nxt;
  logic                en_q;
  logic [3:0]          reg_q;
  logic [DATA_WIDTH:0] data_q;
  logic                grant;
  logic                rsv_fire;
  logic                clr_hit;

  always_comb begin
    alu_ready = ~rst & alu_valid & (~mem_valid | ~ptr);
    mem_ready = ~rst & mem_valid & (~alu_valid | ptr);
    grant     = alu_ready | mem_ready;
  end

  // A write registered just before reset must never appear on the port,
  // so the registered drive is masked while rst is high.
  always_comb begin
    rf_enable = en_q & ~rst;
    rf_InReg  = rst ? 4'd0 : reg_q;
    rf_In     = rst ? '0 : data_q;
  end

  // A register whose busy bit is being cleared this cycle may be re-reserved.
  always_comb begin
    clr_hit   = rf_enable & (rf_InReg == rsv_reg);
    rsv_ready = ~rst & (~busy[rsv_reg] | clr_hit);
    rsv_fire  = rsv_valid & rsv_ready;
  end

  // Clear first, then set, so a same-cycle reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (rf_enable)
      busy_nxt[rf_InReg] = 1'b0;
    if (rsv_fire)
      busy_nxt[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= 1'b0;
      busy   <= '0;
      en_q   <= 1'b0;
      reg_q  <= 4'd0;
      data_q <= '0;
    end else begin
      en_q <= grant;
      busy <= busy_nxt;
      if (grant) begin
        ptr    <= ~ptr;
        reg_q  <= alu_ready ? alu_reg : mem_reg;
        data_q <= alu_ready ? alu_data : mem_data;
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  always_comb begin
    fwd_a_hit  = rf_enable & (rf_InReg == rd_a);
    fwd_b_hit  = rf_enable & (rf_InReg == rd_b);
    fwd_a_data = rf_In;
    fwd_b_data = rf_In;
  end
`else
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
  end
`endif

  // A source covered by a forwarding hit is not a stall.
  always_comb begin
    hazard = ~rst & ((busy[rd_a] & ~fwd_a_hit) |
                     (busy[rd_b] & ~fwd_b_hit));
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Testbench for regfile_wb_sched: per-cycle vector table plus write scoreboard.
// Ports: none; drives the DUT and prints one summary line.
module tb_regfile_wb_sched;

  localparam int DW = 31;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, rsv_valid;
  logic [3:0]    alu_reg, mem_reg, rsv_reg, rd_a, rd_b;
  logic [DW:0]   alu_data, mem_data;
  logic          alu_ready, mem_ready, rsv_ready, hazard;
  logic          rf_enable;
  logic [3:0]    rf_InReg;
  logic [DW:0]   rf_In;
  logic          fwd_a_hit, fwd_b_hit;
  logic [DW:0]   fwd_a_data, fwd_b_data;

  always #5 clk = ~clk;

  regfile_wb_sched #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .rsv_ready(rsv_ready),
    .rd_a(rd_a), .rd_b(rd_b), .hazard(hazard),
    .rf_enable(rf_enable), .rf_InReg(rf_InReg),
    .rf_In(rf_In),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [3:0]  mr;
    logic [31:0] md;
    logic        sv;
    logic [3:0]  sr;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        ea;
    logic        em;
    logic        es;
    logic        ehz;
    logic        ehzb;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[28];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp, input int row);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    //        rst av ar  ad        mv mr  md       sv sr   ra  rb  ea em es hz hzb ee
    vecs[0]  = '{1,1,5,32'h1234,   0,0,0,          0,0,    0,0,  0,0,0,0,0,0};
    vecs[1]  = '{1,0,0,0,          0,0,0,          0,0,    0,0,  0,0,0,0,0,0};
    vecs[2]  = '{0,1,5,32'h1234,   0,0,0,          0,0,    0,0,  1,0,1,0,0,0};
    vecs[3]  = '{0,0,0,0,          0,0,0,          0,0,    0,0,  0,0,1,0,0,1};
    vecs[4]  = '{1,0,0,0,          0,0,0,          0,0,    0,0,  0,0,0,0,0,0};
    vecs[5]  = '{0,1,1,32'hA1,     1,2,32'hB1,     0,0,    0,0,  1,0,1,0,0,0};
    vecs[6]  = '{0,1,1,32'hA2,     1,2,32'hB1,     0,0,    0,0,  0,1,1,0,0,1};
    vecs[7]  = '{0,1,1,32'hA2,     1,2,32'hB2,     0,0,    0,0,  1,0,1,0,0,1};
    vecs[8]  = '{0,1,1,32'hA4,     1,2,32'hB2,     0,0,    0,0,  0,1,1,0,0,1};
    vecs[9]  = '{0,1,1,32'hA4,     0,0,0,          0,0,    0,0,  1,0,1,0,0,1};
    vecs[10] = '{0,0,0,0,          0,0,0,          0,0,    0,0,  0,0,1,0,0,1};
    vecs[11] = '{0,0,0,0,          0,0,0,          1,7,    0,0,  0,0,1,0,0,0};
    vecs[12] = '{0,0,0,0,          0,0,0,          0,0,    7,0,  0,0,1,1,1,0};
    vecs[13] = '{0,0,0,0,          1,7,32'h77,     0,0,    7,0,  0,1,1,1,1,0};
    vecs[14] = '{0,0,0,0,          0,0,0,          0,0,    7,0,  0,0,1,1,0,1};
    vecs[15] = '{0,0,0,0,          0,0,0,          0,0,    7,0,  0,0,1,0,0,0};
    vecs[16] = '{0,0,0,0,          0,0,0,          1,3,    0,0,  0,0,1,0,0,0};
    vecs[17] = '{0,1,3,32'h33,     0,0,0,          1,3,    3,0,  1,0,0,1,1,0};
    vecs[18] = '{0,0,0,0,          0,0,0,          1,3,    3,0,  0,0,1,1,0,1};
    vecs[19] = '{0,0,0,0,          0,0,0,          0,3,    3,0,  0,0,0,1,1,0};
    vecs[20] = '{0,1,9,32'h99,     0,0,0,          0,0,    0,0,  1,0,1,0,0,0};
    vecs[21] = '{1,0,0,0,          0,0,0,          1,3,    3,0,  0,0,0,0,0,0};
    vecs[22] = '{0,1,4,32'h44,     1,6,32'h66,     0,0,    3,9,  1,0,1,0,0,0};
    vecs[23] = '{0,0,0,0,          1,6,32'h66,     0,0,    3,9,  0,1,1,0,0,1};
    vecs[24] = '{0,0,0,0,          0,0,0,          0,0,    0,0,  0,0,1,0,0,1};
    vecs[25] = '{0,0,0,0,          0,0,0,          1,15,   0,0,  0,0,1,0,0,0};
    vecs[26] = '{0,0,0,0,          0,0,0,          0,0,    15,0, 0,0,1,1,1,0};
    vecs[27] = '{0,0,0,0,          0,0,0,          1,15,   0,15, 0,0,0,1,1,0};

    rst = 1'b1;
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    rsv_valid = 0; rsv_reg = 0; rd_a = 0; rd_b = 0;

    for (int i = 0; i < 28; i++) begin
      vec_t v;
      wr_t  w;
      logic ehit_a, ehit_b, ehz;
      v = vecs[i];
      @(posedge clk);
      #1;
      rst = v.rst;
      alu_valid = v.av; alu_reg = v.ar; alu_data = v.ad;
      mem_valid = v.mv; mem_reg = v.mr; mem_data = v.md;
      rsv_valid = v.sv; rsv_reg = v.sr;
      rd_a = v.ra; rd_b = v.rb;
      // outstanding writes are dropped by reset
      if (v.rst) sb.delete();
      @(negedge clk);
      chk("alu_ready", 32'(alu_ready), 32'(v.ea), i);
      chk("mem_ready", 32'(mem_ready), 32'(v.em), i);
      chk("rsv_ready", 32'(rsv_ready), 32'(v.es), i);
      chk("rf_enable", 32'(rf_enable), 32'(v.ee), i);
      w = '{4'd0, 32'd0};
      if (v.ee) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty row %0d", i);
        end else begin
          w = sb.pop_front();
          chk("rf_InReg", 32'(rf_InReg), 32'(w.r), i);
          chk("rf_In", rf_In, w.d, i);
        end
      end
      if (v.rst) begin
        chk("rst_InReg", 32'(rf_InReg), 32'd0, i);
        chk("rst_In", rf_In, 32'd0, i);
      end
`ifdef REGFILE_WB_BYPASS_EN
      ehz    = v.ehzb;
      ehit_a = v.ee & (w.r == v.ra);
      ehit_b = v.ee & (w.r == v.rb);
      if (ehit_a) chk("fwd_a_data", fwd_a_data, w.d, i);
      if (ehit_b) chk("fwd_b_data", fwd_b_data, w.d, i);
`else
      ehz    = v.ehz;
      ehit_a = 1'b0;
      ehit_b = 1'b0;
      chk("fwd_a_data", fwd_a_data, 32'd0, i);
      chk("fwd_b_data", fwd_b_data, 32'd0, i);
`endif
      chk("hazard", 32'(hazard), 32'(ehz), i);
      chk("fwd_a_hit", 32'(fwd_a_hit), 32'(ehit_a), i);
      chk("fwd_b_hit", 32'(fwd_b_hit), 32'(ehit_b), i);
      if (v.ea) sb.push_back('{v.ar, v.ad});
      if (v.em) sb.push_back('{v.mr, v.md});
    end

    @(posedge clk);
    #1;
    alu_valid = 0; mem_valid = 0; rsv_valid = 0;
    @(negedge clk);
    chk("final_rf_enable", 32'(rf_enable), 32'd0, 99);
    chk("sb_drained", 32'(sb.size()), 32'd0, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
